// File: rtl/ram_copy_engine.sv
// Block-move DMA driving a dual-port RAM: reads on port A, writes on port B.
// Define RAMCOPY_FILL_EN to enable pattern-fill mode via fill/fill_data.
module ram_copy_engine #(
    parameter int WIDTHAD = 16,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTHAD-1:0] src,
    input  logic [WIDTHAD-1:0] dst,
    input  logic [WIDTHAD-1:0] len,
    input  logic               fill,
    input  logic [WIDTH-1:0]   fill_data,
    output logic               busy,
    output logic               done,
    output logic [WIDTHAD-1:0] address_a,
    output logic               rden_a,
    output logic               wren_a,
    output logic [WIDTH-1:0]   data_a,
    input  logic [WIDTH-1:0]   q_a,
    output logic [WIDTHAD-1:0] address_b,
    output logic               wren_b,
    output logic [WIDTH-1:0]   data_b,
    output logic               rden_b
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [WIDTHAD-1:0] ONE = WIDTHAD'(1);

    state_t             state_q, state_d;
    logic [WIDTHAD-1:0] rd_addr_q, rd_addr_d;
    logic [WIDTHAD-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTHAD-1:0] cnt_q, cnt_d;
    logic               desc_q, desc_d;
    logic               fill_q, fill_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rden_q, rden_d;
    logic               wren_q, wren_d;
    logic [WIDTHAD-1:0] addr_b_q, addr_b_d;
    logic [WIDTH-1:0]   data_b_q, data_b_d;

    logic               fill_req;
    logic               start_desc;
    logic [WIDTHAD-1:0] len_m1;

`ifdef RAMCOPY_FILL_EN
    assign fill_req = fill;
`else
    logic unused_fill;
    assign unused_fill = fill;
    assign fill_req    = 1'b0;
`endif

    assign start_desc = dst > src;
    assign len_m1     = len - ONE;

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        cnt_d     = cnt_q;
        desc_d    = desc_q;
        fill_d    = fill_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rden_d    = rden_q;
        wren_d    = wren_q;
        addr_b_d  = addr_b_q;
        data_b_d  = data_b_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (fill_req) begin
                        state_d   = RUN;
                        fill_d    = 1'b1;
                        desc_d    = 1'b0;
                        busy_d    = 1'b1;
                        wren_d    = 1'b1;
                        addr_b_d  = dst;
                        data_b_d  = fill_data;
                        wr_addr_d = dst + ONE;
                        cnt_d     = len_m1;
                    end else begin
                        state_d   = RUN;
                        fill_d    = 1'b0;
                        desc_d    = start_desc;
                        busy_d    = 1'b1;
                        rden_d    = 1'b1;
                        rd_addr_d = start_desc ? src + len_m1 : src;
                        wr_addr_d = start_desc ? dst + len_m1 : dst;
                        cnt_d     = len_m1;
                    end
                end
            end
            RUN: begin
                if (fill_q) begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        fill_d  = 1'b0;
                        wren_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        addr_b_d  = wr_addr_q;
                        wr_addr_d = wr_addr_q + ONE;
                        cnt_d     = cnt_q - ONE;
                    end
                end else begin
                    // Write side takes q_a straight from the RAM, one cycle behind the read.
                    wren_d    = 1'b1;
                    addr_b_d  = wr_addr_q;
                    data_b_d  = q_a;
                    wr_addr_d = desc_q ? wr_addr_q - ONE : wr_addr_q + ONE;
                    if (cnt_q == '0) begin
                        state_d = DRAIN;
                        rden_d  = 1'b0;
                    end else begin
                        rd_addr_d = desc_q ? rd_addr_q - ONE : rd_addr_q + ONE;
                        cnt_d     = cnt_q - ONE;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
                wren_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            cnt_q     <= '0;
            desc_q    <= 1'b0;
            fill_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rden_q    <= 1'b0;
            wren_q    <= 1'b0;
            addr_b_q  <= '0;
            data_b_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            cnt_q     <= cnt_d;
            desc_q    <= desc_d;
            fill_q    <= fill_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rden_q    <= rden_d;
            wren_q    <= wren_d;
            addr_b_q  <= addr_b_d;
            data_b_q  <= data_b_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign address_a = rd_addr_q;
    assign rden_a    = rden_q;
    assign wren_a    = 1'b0;
    assign data_a    = '0;
    assign address_b = addr_b_q;
    assign wren_b    = wren_q;
    assign data_b    = data_b_q;
    assign rden_b    = 1'b0;

endmodule
